// File: rtl/vstride_port_arbiter_pkg.sv
// Shared stride-file constants and the round-robin one-hot pick helper.
package vstride_port_arbiter_pkg;
  localparam int VS_WIDTH       = 32;
  localparam int VS_NUMREGS     = 8;
  localparam int VS_LOG2NUMREGS = 3;
  localparam int VS_MAXREQ      = 16;
  localparam int VS_MAXREQ_W    = 4;

  // First valid requester at or after ptr, wrapping modulo n (n <= VS_MAXREQ).
  function automatic logic [VS_MAXREQ-1:0] rr_onehot(
    input logic [VS_MAXREQ-1:0] valid,
    input int unsigned          ptr,
    input int unsigned          n
  );
    logic [VS_MAXREQ-1:0]   g;
    logic                   found;
    logic [VS_MAXREQ_W-1:0] idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < VS_MAXREQ; i++) begin
      idx = VS_MAXREQ_W'((ptr + i) % n);
      if (i < n && !found && valid[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/vstride_rr_pick.sv
// Combinational rotate-priority-unrotate pick: one-hot grant from req_valid and rr_ptr.
module vstride_rr_pick
  import vstride_port_arbiter_pkg::*;
#(
  parameter int NUMREQ     = 2,
  parameter int LOG2NUMREQ = 1
) (
  input  logic [NUMREQ-1:0]     req_valid,
  input  logic [LOG2NUMREQ-1:0] rr_ptr,
  output logic [NUMREQ-1:0]     grant
);
  assign grant = NUMREQ'(rr_onehot(VS_MAXREQ'(req_valid), 32'(rr_ptr), NUMREQ));
endmodule

// File: rtl/vstride_port_arbiter.sv
// Round-robin share of the stride-file read port plus scalar write pass-through.
// Optional same-cycle write forwarding when VSTRIDE_BYPASS_EN is defined.
module vstride_port_arbiter
  import vstride_port_arbiter_pkg::*;
#(
  parameter int WIDTH       = VS_WIDTH,
  parameter int NUMREGS     = VS_NUMREGS,
  parameter int LOG2NUMREGS = VS_LOG2NUMREGS,
  parameter int NUMREQ      = 2,
  parameter int LOG2NUMREQ  = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          stall,
  input  logic [NUMREQ-1:0]             req_valid,
  input  logic [NUMREQ*LOG2NUMREGS-1:0] req_reg,
  output logic [NUMREQ-1:0]             req_ready,
  output logic [NUMREQ-1:0]             rsp_valid,
  output logic [WIDTH-1:0]              rsp_data,
  input  logic                          wr_en,
  input  logic [LOG2NUMREGS-1:0]        wr_reg,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [LOG2NUMREGS-1:0]        rf_a_reg,
  output logic                          rf_a_en,
  input  logic [WIDTH-1:0]              rf_a_readdataout,
  output logic [LOG2NUMREGS-1:0]        rf_c_reg,
  output logic [WIDTH-1:0]              rf_c_writedatain,
  output logic                          rf_c_we
);
  logic [LOG2NUMREQ-1:0]  r_rr_ptr;
  logic [NUMREQ-1:0]      r_rsp_id;
  logic [NUMREQ-1:0]      w_pick;
  logic [LOG2NUMREQ-1:0]  w_win;
  logic [LOG2NUMREGS-1:0] w_rd_reg;
  logic                   w_grant;

  assign rf_c_reg         = wr_reg;
  assign rf_c_writedatain = wr_data;
  assign rf_c_we          = wr_en;

  vstride_rr_pick #(.NUMREQ(NUMREQ), .LOG2NUMREQ(LOG2NUMREQ)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_pick)
  );

  // Reset is folded in so no grant leaks out while the block is held in reset.
  assign req_ready = (resetn && !stall) ? w_pick : '0;
  assign w_grant   = |req_ready;
  assign rf_a_en   = w_grant;
  assign rf_a_reg  = w_rd_reg;

  always_comb begin
    w_win    = '0;
    w_rd_reg = '0;
    for (int i = 0; i < NUMREQ; i++) begin
      if (req_ready[i]) begin
        w_win    = LOG2NUMREQ'(i);
        w_rd_reg = req_reg[i*LOG2NUMREGS +: LOG2NUMREGS];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr <= '0;
      r_rsp_id <= '0;
    end else begin
      r_rsp_id <= req_ready;
      if (w_grant)
        r_rr_ptr <= (w_win == LOG2NUMREQ'(NUMREQ-1)) ? '0 : w_win + 1'b1;
    end
  end

  assign rsp_valid = r_rsp_id;

`ifdef VSTRIDE_BYPASS_EN
  logic             r_byp_vld;
  logic [WIDTH-1:0] r_byp_data;
  logic             w_collide;

  // The file returns stale data on a same-cycle read/write to one index.
  assign w_collide = w_grant && wr_en && (wr_reg == w_rd_reg);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_byp_vld  <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_byp_vld <= w_collide;
      if (w_collide) r_byp_data <= wr_data;
    end
  end

  assign rsp_data = !(|r_rsp_id) ? '0 : (r_byp_vld ? r_byp_data : rf_a_readdataout);
`else
  assign rsp_data = (|r_rsp_id) ? rf_a_readdataout : '0;
`endif
endmodule

// File: tb/tb_vstride_port_arbiter.sv
// Directed bench for vstride_port_arbiter with a behavioural stride register file.
module tb_vstride_port_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;
  logic [1:0]  req_valid;
  logic [5:0]  req_reg;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        wr_en;
  logic [2:0]  wr_reg;
  logic [31:0] wr_data;
  logic [2:0]  rf_a_reg;
  logic        rf_a_en;
  logic [31:0] rf_a_readdataout;
  logic [2:0]  rf_c_reg;
  logic [31:0] rf_c_writedatain;
  logic        rf_c_we;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vstride_port_arbiter dut (
    .clk(clk), .resetn(resetn), .stall(stall),
    .req_valid(req_valid), .req_reg(req_reg), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rf_a_reg(rf_a_reg), .rf_a_en(rf_a_en), .rf_a_readdataout(rf_a_readdataout),
    .rf_c_reg(rf_c_reg), .rf_c_writedatain(rf_c_writedatain), .rf_c_we(rf_c_we)
  );

  // Register file: read captured at the edge (old data on collision), write at the same edge.
  logic [31:0] mem [8];
  logic [31:0] rd_q = '0;
  always @(posedge clk) begin
    if (rf_a_en)  rd_q <= mem[rf_a_reg];
    if (rf_c_we)  mem[rf_c_reg] <= rf_c_writedatain;
  end
  assign rf_a_readdataout = rd_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [1:0] rdy, input logic [1:0] rv,
                      input logic [31:0] rd);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rv));
    chk({tag, ".rsp_data"},  rsp_data, rd);
  endtask

  logic [31:0] exp_coll;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    resetn = 1'b0; stall = 1'b0;
    req_valid = 2'b11; req_reg = {3'd5, 3'd3};
    wr_en = 1'b1; wr_reg = 3'd3; wr_data = 32'h30;
    cyc();
    wr_reg = 3'd5; wr_data = 32'h50;
    cyc();
    wr_reg = 3'd2; wr_data = 32'h11;
    cyc();
    wr_en = 1'b0;
    @(negedge clk);
    chk3("reset", 2'b00, 2'b00, 32'h0);
    chk("reset.rf_a_en", 32'(rf_a_en), 32'd0);
    cyc();

    // C0: release, rr_ptr=0 picks requester 0
    resetn = 1'b1;
    @(negedge clk);
    chk3("rel", 2'b01, 2'b00, 32'h0);
    chk("rel.rf_a_reg", 32'(rf_a_reg), 32'd3);
    chk("rel.rf_a_en", 32'(rf_a_en), 32'd1);
    cyc();
    // C1..C3: alternating grants, responses one cycle behind
    @(negedge clk); chk3("rr1", 2'b10, 2'b01, 32'h30);
    chk("rr1.rf_a_reg", 32'(rf_a_reg), 32'd5);
    cyc();
    @(negedge clk); chk3("rr2", 2'b01, 2'b10, 32'h50); cyc();
    @(negedge clk); chk3("rr3", 2'b10, 2'b01, 32'h30); cyc();

    // C4..C7: only requester 1, granted every cycle
    req_valid = 2'b10;
    @(negedge clk); chk3("single0", 2'b10, 2'b10, 32'h50); cyc();
    @(negedge clk); chk3("single1", 2'b10, 2'b10, 32'h50); cyc();
    @(negedge clk); chk3("single2", 2'b10, 2'b10, 32'h50); cyc();
    @(negedge clk); chk3("single3", 2'b10, 2'b10, 32'h50); cyc();

    // C8..C12: stall two cycles mid-stream
    req_valid = 2'b11;
    @(negedge clk); chk3("prestall", 2'b01, 2'b10, 32'h50); cyc();
    stall = 1'b1;
    @(negedge clk); chk3("stall0", 2'b00, 2'b01, 32'h30);
    chk("stall0.rf_a_en", 32'(rf_a_en), 32'd0);
    cyc();
    @(negedge clk); chk3("stall1", 2'b00, 2'b00, 32'h0); cyc();
    stall = 1'b0;
    @(negedge clk); chk3("poststall", 2'b10, 2'b00, 32'h0); cyc();
    req_valid = 2'b00;
    @(negedge clk); chk3("drain", 2'b00, 2'b10, 32'h50); cyc();

    // C13: same-cycle write to the granted index
    req_valid = 2'b01; req_reg = {3'd5, 3'd2};
    wr_en = 1'b1; wr_reg = 3'd2; wr_data = 32'h22;
    @(negedge clk);
    chk("coll.req_ready", 32'(req_ready), 32'b01);
    chk("coll.rf_a_reg", 32'(rf_a_reg), 32'd2);
    chk("coll.rf_c_we", 32'(rf_c_we), 32'd1);
    chk("coll.rf_c_reg", 32'(rf_c_reg), 32'd2);
    chk("coll.rf_c_wd", rf_c_writedatain, 32'h22);
    cyc();
    wr_en = 1'b0; req_valid = 2'b00;
`ifdef VSTRIDE_BYPASS_EN
    exp_coll = 32'h22;
`else
    exp_coll = 32'h11;
`endif
    @(negedge clk); chk3("collrsp", 2'b00, 2'b01, exp_coll); cyc();
    req_valid = 2'b01;
    @(negedge clk); chk3("reread", 2'b01, 2'b00, 32'h0); cyc();
    req_valid = 2'b00;
    @(negedge clk); chk3("rereadrsp", 2'b00, 2'b01, 32'h22); cyc();

    // Reset mid-flight: grant, then reset before the response is consumed
    req_valid = 2'b10; req_reg = {3'd5, 3'd3};
    @(negedge clk); chk3("mf.grant", 2'b10, 2'b00, 32'h0); cyc();
    resetn = 1'b0; req_valid = 2'b00;
    @(negedge clk); chk3("mf.rst", 2'b00, 2'b00, 32'h0); cyc();
    resetn = 1'b1; req_valid = 2'b11;
    @(negedge clk); chk3("mf.rel", 2'b01, 2'b00, 32'h0); cyc();
    req_valid = 2'b00;
    @(negedge clk); chk3("mf.rsp", 2'b00, 2'b01, 32'h30); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
